pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage core. It merges per-stage stall requests into the 6-bit stall vector consumed by pc, if_id, id_exe, exe_mem and mem_wb. It generates the jump flush and the interrupt flush, sequencing interrupt entry through a small FSM so the trap is taken at a precise instruction. It also watches for pipeline lock-ups with a stall-timeout counter.

Parameters:
STALL_TIMEOUT, 1024, consecutive stalled cycles before the sticky timeout flag sets (≥2)
CNT_WIDTH, 11, width of the stall counter; must hold STALL_TIMEOUT

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous reset, active-high
stall_if_i  input  1  fetch bus wait
stall_id_i  input  1  load-use hazard from id
stall_exe_i  input  1  multi-cycle exe op (div) busy
stall_mem_i  input  1  data bus wait
jump_req_i  input  1  exe resolved taken branch/jump
exe_valid_i  input  1  exe holds a real instruction (not NOP bubble)
exe_pc_i  input  32  pc of instruction in exe
int_req_i  input  1  level interrupt request from clint
int_en_i  input  1  mstatus.MIE
stall_o  output  6  [0]pc [1]if_id [2]id_exe [3]exe_mem [4]mem_wb [5]wb; 1=STOP
flush_jump_o  output  1  flush if_id/id_exe for jump
flush_int_o  output  1  flush for interrupt entry
int_ack_o  output  1  one-cycle pulse: trap taken
int_epc_o  output  32  saved pc for mepc
stall_timeout_o  output  1  sticky lock-up flag

Behaviour:
- Stall vector is combinational. Highest requesting stage wins:
  - stall_mem_i → 6'b011111
  - else stall_exe_i → 6'b001111
  - else stall_id_i → 6'b000111
  - else stall_if_i → 6'b000011
  - else 6'b000000
- With this encoding, id_exe inserts a bubble on a load-use stall (bit2=1, bit3=0).
- flush_jump_o = jump_req_i & ~stall_mem_i, combinational.
  - A jump presented during a mem wait is held by exe (exe_mem stalled) and flushes in the first non-mem-stall cycle.
  - Flush has priority over stall in the downstream registers; pipe_ctrl does not mask stall_o on a flush.
- Interrupt FSM states, all transitions on posedge clk_i:
  - IDLE: go to WAIT when int_req_i & int_en_i.
  - WAIT: take condition = int_req_i & int_en_i & exe_valid_i & ~stall_mem_i & ~stall_exe_i & ~jump_req_i.
    - On take: flush_int_o=1 combinationally in that cycle, latch int_epc_o<=exe_pc_i, go to ACK.
    - If int_req_i or int_en_i drops while in WAIT: return to IDLE, no flush.
    - Jump always wins over the interrupt. The interrupt is retried on a later valid instruction.
  - ACK: int_ack_o=1 for exactly this one cycle (registered Moore output), then go to HOLD.
  - HOLD: stay until int_req_i==0, then IDLE. This prevents a re-trap on the same level request.
- flush_int_o is asserted only in the WAIT take cycle, never in IDLE/ACK/HOLD.
- Stall counter:
  - Increments each cycle stall_o != 0; clears to 0 on any cycle with stall_o == 0.
  - Saturates at STALL_TIMEOUT.
  - stall_timeout_o sets when the counter reaches STALL_TIMEOUT and stays set until rst_i.
- Reset values (rst_i=1 at posedge): state=IDLE, int_ack_o=0, int_epc_o=0, counter=0, stall_timeout_o=0.
  - Combinational outputs follow their inputs during reset, except flush_int_o, which is 0 because state=IDLE.
  - Reset mid-WAIT/ACK/HOLD aborts to IDLE with no ack pulse.
- Simultaneous events:
  - jump_req_i & take conditions otherwise met → flush_jump_o=1, flush_int_o=0, state stays WAIT.
  - stall_mem_i & jump_req_i → both flushes 0.

Test Plan:
- stall_id_i=1 only → stall_o=6'b000111; add stall_mem_i=1 → 6'b011111; all low → 6'b000000.
- jump_req_i=1 with stall_mem_i=1 for 3 cycles, then stall_mem_i=0 → flush_jump_o=0 for 3 cycles, then 1 in cycle 4.
- int_req_i=1, int_en_i=1, exe_valid_i=1, exe_pc_i=32'h0000_0120 → flush_int_o=1 in the WAIT take cycle, int_epc_o=32'h120 next cycle, int_ack_o=1 exactly one cycle later; no second ack while int_req_i stays high.
- Interrupt pending with jump_req_i=1 in the take cycle → flush_jump_o=1, flush_int_o=0; next cycle exe_valid_i=1, exe_pc_i=32'h200 → flush_int_o=1, int_epc_o=32'h200.
- STALL_TIMEOUT=4, stall_exe_i held 4 cycles → stall_timeout_o=1 after 4th stalled cycle; remains 1 after stalls drop; clears only on rst_i.
- rst_i asserted while in ACK → int_ack_o=0, state IDLE, int_epc_o=0 next cycle.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Central 5-stage pipeline controller: stall vector merge, jump/interrupt flush,
// precise interrupt entry sequencing and a sticky stall-timeout lock-up detector.
module pipe_ctrl #(
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_WIDTH     = 11
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_if_i,
  input  logic        stall_id_i,
  input  logic        stall_exe_i,
  input  logic        stall_mem_i,
  input  logic        jump_req_i,
  input  logic        exe_valid_i,
  input  logic [31:0] exe_pc_i,
  input  logic        int_req_i,
  input  logic        int_en_i,
  output logic [5:0]  stall_o,
  output logic        flush_jump_o,
  output logic        flush_int_o,
  output logic        int_ack_o,
  output logic [31:0] int_epc_o,
  output logic        stall_timeout_o
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_e;

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(STALL_TIMEOUT);

  state_e               state_q, state_d;
  logic                 int_ack_q, int_ack_d;
  logic [31:0]          int_epc_q, int_epc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;
  logic                 int_pend, take, flush_int;

  // The most downstream stalling stage freezes itself and everything upstream.
  always_comb begin
    stall_o = 6'b000000;
    if (stall_mem_i)      stall_o = 6'b011111;
    else if (stall_exe_i) stall_o = 6'b001111;
    else if (stall_id_i)  stall_o = 6'b000111;
    else if (stall_if_i)  stall_o = 6'b000011;
  end

  assign flush_jump_o = jump_req_i & ~stall_mem_i;

  assign int_pend = int_req_i & int_en_i;
  assign take     = int_pend & exe_valid_i & ~stall_mem_i & ~stall_exe_i & ~jump_req_i;

  always_comb begin
    state_d   = state_q;
    flush_int = 1'b0;
    int_ack_d = 1'b0;
    int_epc_d = int_epc_q;
    case (state_q)
      IDLE: if (int_pend) state_d = WAIT;
      WAIT: begin
        if (!int_pend) begin
          state_d = IDLE;
        end else if (take) begin
          flush_int = 1'b1;
          int_epc_d = exe_pc_i;
          int_ack_d = 1'b1;
          state_d   = ACK;
        end
      end
      ACK:  state_d = HOLD;
      // Wait for the level request to drop so the same request cannot trap twice.
      HOLD: if (!int_req_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign flush_int_o = flush_int & ~rst_i;

  always_comb begin
    if (stall_o == 6'b000000)   cnt_d = '0;
    else if (cnt_q == TIMEOUT_C) cnt_d = cnt_q;
    else                         cnt_d = cnt_q + 1'b1;
    timeout_d = timeout_q | (cnt_d == TIMEOUT_C);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      int_ack_q <= 1'b0;
      int_epc_q <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      int_ack_q <= int_ack_d;
      int_epc_q <= int_epc_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign int_ack_o       = int_ack_q;
  assign int_epc_o       = int_epc_q;
  assign stall_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl with a small stall timeout.
module tb_pipe_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_if_i, stall_id_i, stall_exe_i, stall_mem_i;
  logic        jump_req_i, exe_valid_i;
  logic [31:0] exe_pc_i;
  logic        int_req_i, int_en_i;
  logic [5:0]  stall_o;
  logic        flush_jump_o, flush_int_o, int_ack_o, stall_timeout_o;
  logic [31:0] int_epc_o;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;

  logic [31:0] epc_q[$];
  logic [5:0]  stall_exp_q[$];

  pipe_ctrl #(.STALL_TIMEOUT(4), .CNT_WIDTH(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .stall_if_i(stall_if_i), .stall_id_i(stall_id_i),
    .stall_exe_i(stall_exe_i), .stall_mem_i(stall_mem_i),
    .jump_req_i(jump_req_i), .exe_valid_i(exe_valid_i), .exe_pc_i(exe_pc_i),
    .int_req_i(int_req_i), .int_en_i(int_en_i),
    .stall_o(stall_o), .flush_jump_o(flush_jump_o), .flush_int_o(flush_int_o),
    .int_ack_o(int_ack_o), .int_epc_o(int_epc_o), .stall_timeout_o(stall_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Every ack must match a previously scheduled interrupt entry.
  always @(negedge clk_i) begin
    if (int_ack_o === 1'b1) begin
      ack_cnt++;
      if (epc_q.size() == 0) check_eq("ack_spurious", 1, 0);
      else                   check_eq("int_epc", int_epc_o, epc_q.pop_front());
    end
  end

  logic [3:0] pat [5];
  logic [5:0] pat_exp [5];

  initial begin
    // {mem, exe, id, if}
    pat[0] = 4'b0010; pat_exp[0] = 6'b000111;
    pat[1] = 4'b1010; pat_exp[1] = 6'b011111;
    pat[2] = 4'b0000; pat_exp[2] = 6'b000000;
    pat[3] = 4'b0001; pat_exp[3] = 6'b000011;
    pat[4] = 4'b0111; pat_exp[4] = 6'b001111;

    rst_i = 1'b1;
    {stall_if_i, stall_id_i, stall_exe_i, stall_mem_i} = 4'b0;
    jump_req_i = 0; exe_valid_i = 0; exe_pc_i = 32'h0;
    int_req_i = 0; int_en_i = 0;
    tick(); tick();
    @(negedge clk_i);
    check_eq("rst_stall", stall_o, 6'b0);
    check_eq("rst_ack", int_ack_o, 0);
    check_eq("rst_epc", int_epc_o, 0);
    check_eq("rst_timeout", stall_timeout_o, 0);
    check_eq("rst_flush_int", flush_int_o, 0);
    tick();
    rst_i = 1'b0;

    // Stall vector priority
    for (int i = 0; i < 5; i++) begin
      {stall_mem_i, stall_exe_i, stall_id_i, stall_if_i} = pat[i];
      stall_exp_q.push_back(pat_exp[i]);
      @(negedge clk_i);
      check_eq($sformatf("stall_pat%0d", i), stall_o, stall_exp_q.pop_front());
      tick();
    end
    {stall_mem_i, stall_exe_i, stall_id_i, stall_if_i} = 4'b0;
    tick();
    check_eq("no_timeout_short", stall_timeout_o, 0);

    // Jump held during mem wait
    jump_req_i = 1; stall_mem_i = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_eq($sformatf("jump_memwait%0d", i), flush_jump_o, 0);
      tick();
    end
    stall_mem_i = 0;
    @(negedge clk_i);
    check_eq("jump_release", flush_jump_o, 1);
    tick();
    jump_req_i = 0;

    // Basic interrupt entry
    int_req_i = 1; int_en_i = 1; exe_valid_i = 1; exe_pc_i = 32'h120;
    @(negedge clk_i);
    check_eq("int_idle_noflush", flush_int_o, 0);
    tick();
    @(negedge clk_i);
    check_eq("int_take_flush", flush_int_o, 1);
    epc_q.push_back(32'h120);
    tick();
    @(negedge clk_i);
    check_eq("int_ack_flush0", flush_int_o, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk_i);
      check_eq($sformatf("int_hold_flush%0d", i), flush_int_o, 0);
    end
    check_eq("int_ack_count1", ack_cnt, 1);
    int_req_i = 0;
    tick();

    // Jump beats a pending interrupt, interrupt retried next instruction
    int_req_i = 1; exe_pc_i = 32'h1f0;
    tick();
    jump_req_i = 1;
    @(negedge clk_i);
    check_eq("ij_flush_jump", flush_jump_o, 1);
    check_eq("ij_flush_int", flush_int_o, 0);
    tick();
    jump_req_i = 0; exe_pc_i = 32'h200;
    @(negedge clk_i);
    check_eq("ij_retry_flush", flush_int_o, 1);
    epc_q.push_back(32'h200);
    tick(); tick();
    int_req_i = 0;
    tick();
    check_eq("int_ack_count2", ack_cnt, 2);

    // Exe stall blocks the take; enable drop returns to IDLE
    int_req_i = 1; stall_exe_i = 1;
    tick();
    @(negedge clk_i);
    check_eq("wait_exe_stall", flush_int_o, 0);
    int_en_i = 0;
    #1 check_eq("wait_en_drop", flush_int_o, 0);
    tick();
    int_en_i = 1; stall_exe_i = 0;
    #1 check_eq("back_to_idle", flush_int_o, 0);
    int_req_i = 0;
    tick(); tick();

    // Reset while in ACK
    int_req_i = 1; exe_pc_i = 32'h340;
    tick();
    @(negedge clk_i);
    check_eq("rack_take", flush_int_o, 1);
    epc_q.push_back(32'h340);
    tick();
    rst_i = 1;
    tick();
    @(negedge clk_i);
    check_eq("rack_ack", int_ack_o, 0);
    check_eq("rack_epc", int_epc_o, 0);
    check_eq("rack_flush_int", flush_int_o, 0);
    stall_id_i = 1;
    #1 check_eq("rst_stall_follow", stall_o, 6'b000111);
    stall_id_i = 0; int_req_i = 0;
    tick();
    rst_i = 0;
    check_eq("int_ack_count3", ack_cnt, 3);

    // Stall timeout
    stall_exe_i = 1;
    for (int i = 0; i < 3; i++) tick();
    check_eq("timeout_3", stall_timeout_o, 0);
    tick();
    check_eq("timeout_4", stall_timeout_o, 1);
    stall_exe_i = 0;
    tick(); tick();
    check_eq("timeout_sticky", stall_timeout_o, 1);
    rst_i = 1;
    tick();
    check_eq("timeout_rst", stall_timeout_o, 0);
    rst_i = 0;
    tick();

    check_eq("epc_q_empty", epc_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
